// File: rtl/spi_pkg.sv
// Shared types for the SPI byte sequencer: transfer FSM states and byte width.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_STORE
    } fsm_state_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Byte FIFO with first-word fall-through read; pushes while full are dropped
// and flagged on OVF_PULSE, pops while empty are ignored.
module spi_byte_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  WR,
    input  logic [SPI_BYTE_W-1:0] WDATA,
    output logic                  FULL,
    input  logic                  RD,
    output logic [SPI_BYTE_W-1:0] RDATA,
    output logic                  EMPTY,
    output logic                  OVF_PULSE
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [SPI_BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;
    logic [AW:0]           count_d;
    logic                  full_q;
    logic                  empty_q;
    logic                  push;
    logic                  pop;

    assign push      = WR && !full_q;
    assign pop       = RD && !empty_q;
    assign FULL      = full_q;
    assign EMPTY     = empty_q;
    assign RDATA     = mem_q[rd_ptr_q];
    assign OVF_PULSE = WR && full_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is reset too, so the fall-through head reads 0x00 out of reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= WDATA;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
        end
    end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Launches one SPI master transfer per queued TX byte, tracks BUSY with a
// timeout, and stores each captured DIN byte into the RX FIFO.
module spi_byte_sequencer
    import spi_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  TX_WR,
    input  logic [SPI_BYTE_W-1:0] TX_DATA,
    output logic                  TX_FULL,
    input  logic                  RX_RD,
    output logic [SPI_BYTE_W-1:0] RX_DATA,
    output logic                  RX_EMPTY,
    output logic                  TX_OVF,
    output logic                  TIMEOUT_ERR,
    input  logic                  CLR_ERR,
    output logic                  IDLE,
    output logic                  SPI_START,
    output logic [SPI_BYTE_W-1:0] SPI_DOUT,
    input  logic                  SPI_BUSY,
    input  logic [SPI_BYTE_W-1:0] SPI_DIN
);

    localparam logic [7:0] TIMEOUT_LOAD = 8'(BUSY_TIMEOUT);

    fsm_state_t            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [SPI_BYTE_W-1:0] dout_q, dout_d;
    logic                  start_q;
    logic                  tx_ovf_q;
    logic                  timeout_q;
    logic                  timeout_set;

    logic                  tx_empty;
    logic                  tx_rd;
    logic                  tx_ovf_pulse;
    logic [SPI_BYTE_W-1:0] tx_rdata;
    logic                  rx_full;
    logic                  rx_wr;
    logic                  rx_ovf_unused;

    spi_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .WR        (TX_WR),
        .WDATA     (TX_DATA),
        .FULL      (TX_FULL),
        .RD        (tx_rd),
        .RDATA     (tx_rdata),
        .EMPTY     (tx_empty),
        .OVF_PULSE (tx_ovf_pulse)
    );

    // RX pushes only from S_STORE, which the launch condition keeps from overflowing.
    spi_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .WR        (rx_wr),
        .WDATA     (SPI_DIN),
        .FULL      (rx_full),
        .RD        (RX_RD),
        .RDATA     (RX_DATA),
        .EMPTY     (RX_EMPTY),
        .OVF_PULSE (rx_ovf_unused)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        tx_rd       = 1'b0;
        rx_wr       = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!tx_empty && !rx_full) begin
                    tx_rd   = 1'b1;
                    dout_d  = tx_rdata;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = TIMEOUT_LOAD;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (SPI_BUSY) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == 8'd1) begin
                        timeout_set = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!SPI_BUSY) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                rx_wr   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // START is registered from the next state so it is high for exactly the S_LAUNCH cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dout_q    <= '0;
            start_q   <= 1'b0;
            tx_ovf_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            start_q <= (state_d == S_LAUNCH);
            if (CLR_ERR) begin
                tx_ovf_q  <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                if (tx_ovf_pulse) tx_ovf_q  <= 1'b1;
                if (timeout_set)  timeout_q <= 1'b1;
            end
        end
    end

    assign SPI_START   = start_q;
    assign SPI_DOUT    = dout_q;
    assign TX_OVF      = tx_ovf_q;
    assign TIMEOUT_ERR = timeout_q;
    assign IDLE        = (state_q == S_IDLE) && tx_empty;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer with a behavioural SPI master model.
module tb_spi_byte_sequencer;

    localparam int DEPTH = 8;
    localparam int TMO   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_wr, rx_rd, clr_err;
    logic [7:0] tx_data;
    logic       tx_full, rx_empty, tx_ovf, timeout_err, idle, spi_start, spi_busy;
    logic [7:0] rx_data, spi_dout, spi_din;

    int n_tests = 0;
    int n_fail  = 0;

    bit         master_en  = 1'b0;
    bit         miso_inv   = 1'b0;
    logic [7:0] miso_val   = 8'h00;
    int         busy_len   = 3;
    int         start_cnt  = 0;
    int         dout_glitch = 0;
    logic [7:0] launched[$];

    spi_byte_sequencer #(.DEPTH(DEPTH), .BUSY_TIMEOUT(TMO)) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .TX_WR       (tx_wr),
        .TX_DATA     (tx_data),
        .TX_FULL     (tx_full),
        .RX_RD       (rx_rd),
        .RX_DATA     (rx_data),
        .RX_EMPTY    (rx_empty),
        .TX_OVF      (tx_ovf),
        .TIMEOUT_ERR (timeout_err),
        .CLR_ERR     (clr_err),
        .IDLE        (idle),
        .SPI_START   (spi_start),
        .SPI_DOUT    (spi_dout),
        .SPI_BUSY    (spi_busy),
        .SPI_DIN     (spi_din)
    );

    always #5 clk = ~clk;

    // Master model: raises BUSY mid-cycle after seeing START, holds it busy_len cycles.
    initial begin : master
        logic [7:0] cap;
        spi_busy = 1'b0;
        spi_din  = 8'h00;
        forever begin
            @(negedge clk);
            if (spi_start === 1'b1) begin
                start_cnt++;
                if (master_en) begin
                    cap = spi_dout;
                    launched.push_back(cap);
                    spi_busy = 1'b1;
                    repeat (busy_len) begin
                        @(negedge clk);
                        if (spi_dout !== cap) dout_glitch++;
                    end
                    spi_din  = miso_inv ? ~cap : miso_val;
                    spi_busy = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tx_push(input logic [7:0] b);
        tx_wr   = 1'b1;
        tx_data = b;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (!(idle === 1'b1 && spi_busy === 1'b0) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check({tag, "_wait_idle"}, 0, 1);
    endtask

    task automatic wait_start(input string tag);
        int g = 0;
        while (spi_start !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check({tag, "_wait_start"}, 0, 1);
    endtask

    task automatic rx_pop_expect(input string tag, input logic [7:0] exp);
        int g = 0;
        while (rx_empty !== 1'b0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_avail"}, rx_empty, 0);
        check(tag, rx_data, exp);
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"},   spi_start,   0);
        check({tag, "_dout"},    spi_dout,    8'h00);
        check({tag, "_tx_full"}, tx_full,     0);
        check({tag, "_rx_empty"},rx_empty,    1);
        check({tag, "_rx_data"}, rx_data,     8'h00);
        check({tag, "_tx_ovf"},  tx_ovf,      0);
        check({tag, "_tmo"},     timeout_err, 0);
        check({tag, "_idle"},    idle,        1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] drain_exp[$];
        rst_n   = 1'b0;
        tx_wr   = 1'b0;
        rx_rd   = 1'b0;
        clr_err = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset mid-cycle while a byte is waiting for BUSY.
        master_en = 1'b0;
        tx_push(8'h5A);
        repeat (2) @(negedge clk);
        check("arst_pre_dout", spi_dout, 8'h5A);
        check("arst_pre_idle", idle, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-byte loopback 0xA5 -> 0x3C with launch latency checks.
        master_en = 1'b1;
        miso_inv  = 1'b0;
        miso_val  = 8'h3C;
        busy_len  = 3;
        start_cnt = 0;
        dout_glitch = 0;
        launched.delete();
        tx_push(8'hA5);
        check("lb_start_early", spi_start, 0);
        @(negedge clk);
        check("lb_start_k2", spi_start, 1);
        check("lb_dout_k2", spi_dout, 8'hA5);
        wait_idle("lb");
        check("lb_start_cnt", start_cnt, 1);
        check("lb_launched", launched.size() > 0 ? launched[0] : 8'hxx, 8'hA5);
        check("lb_dout_stable", dout_glitch, 0);
        check("lb_idle", idle, 1);
        rx_pop_expect("lb_rx", 8'h3C);
        check("lb_rx_empty_after", rx_empty, 1);

        // Fill RX with 8 results, then the TX queue stalls; overflow TX on top.
        miso_inv = 1'b1;
        busy_len = 2;
        for (int i = 0; i < DEPTH; i++) tx_push(8'h80 + 8'(i));
        wait_idle("fill");
        launched.delete();
        start_cnt = 0;
        for (int i = 0; i <= DEPTH; i++) tx_push(8'(i));
        check("ovf_tx_full", tx_full, 1);
        check("ovf_flag", tx_ovf, 1);
        check("ovf_idle", idle, 0);
        repeat (20) @(negedge clk);
        check("stall_no_start", start_cnt, 0);
        tx_wr   = 1'b1;
        tx_data = 8'hEE;
        clr_err = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
        clr_err = 1'b0;
        check("clr_priority", tx_ovf, 0);
        tx_push(8'hEF);
        check("ovf_reset", tx_ovf, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("ovf_clear", tx_ovf, 0);
        check("ovf_still_full", tx_full, 1);

        rx_pop_expect("stall_rx0", 8'h7F);
        repeat (40) @(negedge clk);
        check("stall_one_more", start_cnt, 1);
        for (int i = 1; i < DEPTH; i++) drain_exp.push_back(~(8'h80 + 8'(i)));
        for (int i = 0; i < DEPTH; i++) drain_exp.push_back(~8'(i));
        foreach (drain_exp[i]) rx_pop_expect($sformatf("drain_%0d", i), drain_exp[i]);
        wait_idle("drain");
        check("drain_rx_empty", rx_empty, 1);
        check("drain_launch_cnt", launched.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("drain_launch_%0d", i), i < launched.size() ? launched[i] : 8'hxx, 8'(i));
        check("drain_dout_stable", dout_glitch, 0);

        // Timeout: BUSY never rises.
        master_en = 1'b0;
        start_cnt = 0;
        tx_push(8'h11);
        tx_push(8'h22);
        wait_start("tmo");
        check("tmo_dout", spi_dout, 8'h11);
        @(negedge clk);
        check("tmo_start_drop", spi_start, 0);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_not_yet", timeout_err, 0);
        @(negedge clk);
        check("tmo_set", timeout_err, 1);
        check("tmo_rx_empty", rx_empty, 1);
        @(negedge clk);
        check("tmo_next_start", spi_start, 1);
        check("tmo_next_dout", spi_dout, 8'h22);
        wait_idle("tmo");
        check("tmo_start_cnt", start_cnt, 2);
        check("tmo_rx_still_empty", rx_empty, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("tmo_clear", timeout_err, 0);

        // Reset while the FSM waits for BUSY to fall.
        master_en = 1'b1;
        busy_len  = 6;
        tx_push(8'h33);
        tx_push(8'h44);
        begin
            int g = 0;
            while (spi_busy !== 1'b1 && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (g >= 100) check("mid_wait_busy", 0, 1);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start_cnt = 0;
        check("mid_idle", idle, 1);
        check("mid_rx_empty", rx_empty, 1);
        check("mid_tx_full", tx_full, 0);
        begin
            int g = 0;
            while (spi_busy !== 1'b0 && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (g >= 100) check("mid_busy_fall", 0, 1);
        end
        repeat (5) @(negedge clk);
        check("mid_no_rx_push", rx_empty, 1);
        check("mid_no_start", start_cnt, 0);
        check("mid_idle_end", idle, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_byte_sequencer.md
# spi_byte_sequencer

Byte-stream front end for the SPI master stage. It buffers outgoing bytes in a TX FIFO and launches one SPI master transfer per byte by pulsing START and holding DOUT. It tracks the master's BUSY through each transfer and pushes the captured DIN byte into an RX FIFO. It sits between the host/register logic and the SPI master, which needs a single-cycle START edge and a DOUT that stays stable for the whole transfer.

## Interface
Parameters:
- DEPTH, 8: entries per FIFO (TX and RX); power of two, 2..256
- BUSY_TIMEOUT, 4: CLK cycles allowed after START for BUSY to rise; 1..255

Ports:
- CLK  in  1  single clock for the block and the SPI master
- RST_N  in  1  asynchronous active-low reset
- TX_WR  in  1  push TX_DATA into the TX FIFO
- TX_DATA  in  8  byte to transmit
- TX_FULL  out  1  TX FIFO full
- RX_RD  in  1  pop the RX FIFO head
- RX_DATA  out  8  RX FIFO head (first-word fall-through), valid when !RX_EMPTY
- RX_EMPTY  out  1  RX FIFO empty
- TX_OVF  out  1  sticky: TX_WR was dropped while full
- TIMEOUT_ERR  out  1  sticky: BUSY did not rise within BUSY_TIMEOUT
- CLR_ERR  in  1  clears TX_OVF and TIMEOUT_ERR; it takes priority over a same-cycle set
- IDLE  out  1  FSM in S_IDLE and TX FIFO empty
- SPI_START  out  1  to master START
- SPI_DOUT  out  8  to master DOUT, registered
- SPI_BUSY  in  1  from master BUSY
- SPI_DIN  in  8  from master DIN

## Operation
- FIFOs:
  - Push when FULL=1 is dropped regardless of a same-cycle pop.
  - Pop when EMPTY=1 is ignored.
  - Push and pop in the same cycle, neither flag set: both take effect, and the count is unchanged.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - The count is log2(DEPTH)+1 bits.
- FSM states: S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_STORE.
- S_IDLE -> S_LAUNCH when TX not empty AND RX not full.
  - Pops TX. Loads SPI_DOUT with the head byte.
  - If RX is full, the FSM stalls in S_IDLE and nothing is launched.
- S_LAUNCH:
  - SPI_START=1 for exactly this one cycle.
  - Loads the timeout counter with BUSY_TIMEOUT.
  - Next state is S_WAIT_BUSY.
- S_WAIT_BUSY:
  - SPI_BUSY=1 -> S_WAIT_DONE.
  - Otherwise decrement the counter. When it reaches 0: set TIMEOUT_ERR, discard the byte, go to S_IDLE.
- S_WAIT_DONE: SPI_BUSY=0 -> S_STORE.
- S_STORE: push SPI_DIN into RX (guaranteed not full by the launch condition), then go to S_IDLE.
- SPI_DOUT holds its value from S_IDLE exit until the next launch; it never changes while BUSY=1.
- Reset values: SPI_START=0, SPI_DOUT=0x00, TX_FULL=0, RX_EMPTY=1, RX_DATA=0x00 (memory reset to 0), TX_OVF=0, TIMEOUT_ERR=0, IDLE=1. The FSM resets to S_IDLE and both FIFOs are emptied.
- Reset mid-transfer: everything returns to reset values immediately. The in-flight byte is lost. The master's own transfer completes unaffected, because SPI_START stays 0.

## Timing
- Launch latency:
  - TX_WR at edge k into an empty TX FIFO, with the FSM in S_IDLE and RX not full.
  - S_IDLE sees TX non-empty at edge k+1, entering S_LAUNCH and updating SPI_DOUT.
  - SPI_START is high during cycle k+2, i.e. from edge k+1 to edge k+2.
- The master raises BUSY asynchronously within cycle k+2. The FSM samples BUSY=1 at edge k+3 at the earliest.
- Result latency:
  - The byte is pushed into RX at the edge leaving S_STORE, one cycle after BUSY is sampled low.
  - RX_EMPTY falls and RX_DATA is valid on the following cycle.
- Back-to-back transfers: S_STORE -> S_IDLE -> S_LAUNCH, so at least 2 idle CLK cycles separate BUSY falling and the next SPI_START.
- All outputs are registered, except RX_DATA (comb read of the head entry) and IDLE.

## Structure
- Shared package spi_pkg:
  - fsm_state_t enum of the five states
  - SPI_BYTE_W = 8
- Sub-module spi_byte_fifo (parameter DEPTH; ports CLK, RST_N, WR, WDATA, FULL, RD, RDATA, EMPTY, OVF_PULSE), instantiated once for TX and once for RX.
- The FSM, timeout counter and sticky error flags live in the top module.

## Test plan
- Reset:
  - Stimulus: assert RST_N=0 asynchronously mid-cycle.
  - Required response: all outputs take their reset values immediately, with IDLE=1 and RX_EMPTY=1.
- Single-byte loopback:
  - Stimulus: write 0xA5 with the master model's MISO returning 0x3C.
  - Required response: exactly one SPI_START pulse; SPI_DOUT=0xA5 throughout BUSY; RX_DATA=0x3C; RX_EMPTY deasserts; IDLE returns to 1.
- TX overflow:
  - Stimulus: with BUSY held low, write DEPTH+1 bytes 0x00..0x08 (DEPTH=8) back-to-back with no RX reads.
  - Required response: TX_FULL asserts; TX_OVF sets; the dropped byte never appears on SPI_DOUT.
  - Then assert CLR_ERR: TX_OVF clears.
- RX-full stall:
  - Stimulus: leave the RX FIFO unread through 8 completed transfers, with 2 more bytes queued in TX.
  - Required response: no further SPI_START; after one RX_RD, exactly one more transfer occurs.
- Timeout:
  - Stimulus: tie SPI_BUSY=0 and write 0x11.
  - Required response: TIMEOUT_ERR sets exactly BUSY_TIMEOUT cycles after SPI_START; RX stays empty; the next queued byte 0x22 still launches.
- Reset mid-transfer:
  - Stimulus: assert reset while in S_WAIT_DONE.
  - Required response: TX and RX are empty after release; no RX push occurs when BUSY later falls.
